// File: rtl/fp_regfile_mp.sv
// ============================================================================
//  fp_regfile_mp : multi-port FP register file with write bypass, per-register
//                  busy scoreboard and hardware clear-after-reset sequence.
//  Revision      : 1.0
// ============================================================================
`default_nettype none

module fp_regfile_mp #(
   parameter int DEPTH      = 32,
   parameter int DATA_WIDTH = 64,
   parameter int NUM_READ   = 3,
   parameter int NUM_WRITE  = 2,
   parameter int BYPASS     = 1,
   localparam int AW        = $clog2(DEPTH)
) (
   input  logic                           i_clk,
   input  logic                           i_rst_n,
   input  logic                           i_stall,
   input  logic [NUM_READ*AW-1:0]         i_rd_addr,
   output logic [NUM_READ*DATA_WIDTH-1:0] o_rd_data,
   output logic [NUM_READ-1:0]            o_rd_busy,
   input  logic [NUM_WRITE-1:0]           i_wr_en,
   input  logic [NUM_WRITE*AW-1:0]        i_wr_addr,
   input  logic [NUM_WRITE*DATA_WIDTH-1:0] i_wr_data,
   input  logic                           i_alloc_en,
   input  logic [AW-1:0]                  i_alloc_addr,
   output logic                           o_ready
);

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_t;

   state_t                state_q, state_d;
   logic [AW-1:0]         clr_idx_q, clr_idx_d;
   logic [DEPTH-1:0]      busy_q, busy_d;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DEPTH];

   logic [NUM_WRITE-1:0]  wr_eff;
   logic                  alloc_eff;

   assign wr_eff    = (state_q == ST_READY) ? (i_wr_en & ~{NUM_WRITE{i_stall}}) : '0;
   assign alloc_eff = (state_q == ST_READY) & i_alloc_en & ~i_stall;
   assign o_ready   = (state_q == ST_READY);

   always_comb begin
      state_d   = state_q;
      clr_idx_d = clr_idx_q;
      if (state_q == ST_CLEAR) begin
         clr_idx_d = clr_idx_q + 1'b1;
         if (clr_idx_q == AW'(DEPTH - 1)) begin
            state_d = ST_READY;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= ST_CLEAR;
         clr_idx_q <= '0;
         busy_q    <= '0;
      end else begin
         state_q   <= state_d;
         clr_idx_q <= clr_idx_d;
         busy_q    <= busy_d;
      end
   end

   // Higher write ports are applied later, so they win address conflicts.
   always_comb begin
      mem_d = mem_q;
      if (state_q == ST_CLEAR) begin
         mem_d[clr_idx_q] = '0;
      end
      for (int k = 0; k < NUM_WRITE; k++) begin
         if (wr_eff[k]) begin
            mem_d[i_wr_addr[k*AW +: AW]] = i_wr_data[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      mem_q <= mem_d;
   end

   // Allocation is applied after completions: the younger producer owns the register.
   always_comb begin
      busy_d = busy_q;
      for (int k = 0; k < NUM_WRITE; k++) begin
         if (wr_eff[k]) begin
            busy_d[i_wr_addr[k*AW +: AW]] = 1'b0;
         end
      end
      if (alloc_eff) begin
         busy_d[i_alloc_addr] = 1'b1;
      end
   end

   for (genvar r = 0; r < NUM_READ; r++) begin : g_rd
      logic [AW-1:0]         rd_addr;
      logic [DATA_WIDTH-1:0] rd_data;
      logic                  rd_busy;

      assign rd_addr = i_rd_addr[r*AW +: AW];

      always_comb begin
         rd_data = mem_q[rd_addr];
         rd_busy = busy_q[rd_addr];
         if (BYPASS != 0) begin
            for (int k = 0; k < NUM_WRITE; k++) begin
               if (wr_eff[k] && (i_wr_addr[k*AW +: AW] == rd_addr)) begin
                  rd_data = i_wr_data[k*DATA_WIDTH +: DATA_WIDTH];
                  rd_busy = 1'b0;
               end
            end
            if (alloc_eff && (i_alloc_addr == rd_addr)) begin
               rd_busy = busy_q[rd_addr];
            end
         end
         if (state_q != ST_READY) begin
            rd_data = '0;
            rd_busy = 1'b0;
         end
      end

      assign o_rd_data[r*DATA_WIDTH +: DATA_WIDTH] = rd_data;
      assign o_rd_busy[r]                          = rd_busy;
   end

endmodule

`default_nettype wire

// File: tb/tb_fp_regfile_mp.sv
// ============================================================================
//  tb_fp_regfile_mp : scoreboard bench driving BYPASS=1 and BYPASS=0 copies
//                     of fp_regfile_mp with identical directed stimulus.
//  Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_fp_regfile_mp;

    localparam int DEPTH = 32;
    localparam int DW    = 64;
    localparam int NR    = 3;
    localparam int NW    = 2;
    localparam int AW    = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic               stall;
    logic [NR*AW-1:0]   rd_addr;
    logic [NW-1:0]      wr_en;
    logic [NW*AW-1:0]   wr_addr;
    logic [NW*DW-1:0]   wr_data;
    logic               alloc_en;
    logic [AW-1:0]      alloc_addr;

    logic [NR*DW-1:0]   data_b1, data_b0;
    logic [NR-1:0]      busy_b1, busy_b0;
    logic               ready_b1, ready_b0;

    fp_regfile_mp #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .NUM_READ(NR), .NUM_WRITE(NW), .BYPASS(1)) u_dut_b1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall),
        .i_rd_addr(rd_addr), .o_rd_data(data_b1), .o_rd_busy(busy_b1),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_alloc_en(alloc_en), .i_alloc_addr(alloc_addr), .o_ready(ready_b1)
    );

    fp_regfile_mp #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .NUM_READ(NR), .NUM_WRITE(NW), .BYPASS(0)) u_dut_b0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall),
        .i_rd_addr(rd_addr), .o_rd_data(data_b0), .o_rd_busy(busy_b0),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_alloc_en(alloc_en), .i_alloc_addr(alloc_addr), .o_ready(ready_b0)
    );

    // kind: 0 = read data, 1 = read busy, 2 = ready
    typedef struct {
        bit             dut;
        int             kind;
        int             port;
        logic [DW-1:0]  val;
        string          name;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic logic [DW-1:0] actual(exp_t e);
        case (e.kind)
            0:       return e.dut ? data_b1[e.port*DW +: DW] : data_b0[e.port*DW +: DW];
            1:       return {{(DW-1){1'b0}}, (e.dut ? busy_b1[e.port] : busy_b0[e.port])};
            default: return {{(DW-1){1'b0}}, (e.dut ? ready_b1 : ready_b0)};
        endcase
    endfunction

    always @(negedge clk) begin : monitor
        exp_t          e;
        logic [DW-1:0] a;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            a = actual(e);
            n_chk++;
            if (a === e.val) begin
                n_pass++;
            end else begin
                $display("FAIL %s bypass=%0d kind=%0d port=%0d: got %h expected %h",
                         e.name, e.dut, e.kind, e.port, a, e.val);
            end
        end
    end

    task automatic push(bit d, int kind, int port, logic [DW-1:0] v, string nm);
        exp_t e;
        e.dut = d; e.kind = kind; e.port = port; e.val = v; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic exp_rd(int p, logic [DW-1:0] v1, logic [DW-1:0] v0, string nm);
        push(1'b1, 0, p, v1, nm);
        push(1'b0, 0, p, v0, nm);
    endtask

    task automatic exp_busy(int p, bit b1, bit b0, string nm);
        push(1'b1, 1, p, {{(DW-1){1'b0}}, b1}, nm);
        push(1'b0, 1, p, {{(DW-1){1'b0}}, b0}, nm);
    endtask

    task automatic exp_ready(bit r, string nm);
        push(1'b1, 2, 0, {{(DW-1){1'b0}}, r}, nm);
        push(1'b0, 2, 0, {{(DW-1){1'b0}}, r}, nm);
    endtask

    task automatic exp_all(logic [DW-1:0] v1, logic [DW-1:0] v0, bit b1, bit b0, string nm);
        for (int p = 0; p < NR; p++) begin
            exp_rd(p, v1, v0, nm);
            exp_busy(p, b1, b0, nm);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en    = '0;
        alloc_en = 1'b0;
        stall    = 1'b0;
    endtask

    task automatic rd_all(logic [AW-1:0] a);
        rd_addr = {a, a, a};
    endtask

    task automatic wr(int k, logic [AW-1:0] a, logic [DW-1:0] d);
        wr_en[k]            = 1'b1;
        wr_addr[k*AW +: AW] = a;
        wr_data[k*DW +: DW] = d;
    endtask

    // Called just after i_rst_n deasserts; returns just after the DEPTH-th edge.
    task automatic clear_seq(string nm);
        for (int i = 0; i < DEPTH; i++) begin
            exp_ready(1'b0, nm);
            cyc();
        end
        idle();
        exp_ready(1'b1, nm);
    endtask

    initial begin
        rst_n      = 1'b0;
        idle();
        rd_addr    = '0;
        wr_addr    = '0;
        wr_data    = '0;
        alloc_addr = '0;

        repeat (2) cyc();
        exp_ready(1'b0, "reset_ready");
        exp_all(64'h0, 64'h0, 1'b0, 1'b0, "reset_out");
        cyc();

        // Release reset with a write and allocation to f5 held through the clear.
        rst_n = 1'b1;
        wr(0, 5'd5, 64'hDEAD_BEEF);
        alloc_en   = 1'b1;
        alloc_addr = 5'd5;
        rd_all(5'd5);
        clear_seq("clear_ready");

        for (int a = 0; a < DEPTH; a++) begin
            rd_all(AW'(a));
            exp_all(64'h0, 64'h0, 1'b0, 1'b0, "post_clear");
            cyc();
        end

        // Basic write then read on all ports
        wr(0, 5'd7, 64'h3FF0_0000_0000_0000);
        rd_all(5'd0);
        cyc();
        idle();
        rd_all(5'd7);
        exp_all(64'h3FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000, 1'b0, 1'b0, "basic");
        cyc();

        // Two ports hit f3; port 1 wins
        wr(0, 5'd3, 64'h1111);
        wr(1, 5'd3, 64'h2222);
        rd_all(5'd3);
        exp_all(64'h2222, 64'h0, 1'b0, 1'b0, "bypass_same");
        cyc();
        idle();
        exp_all(64'h2222, 64'h2222, 1'b0, 1'b0, "bypass_next");
        cyc();

        // Scoreboard on f10
        alloc_en   = 1'b1;
        alloc_addr = 5'd10;
        rd_all(5'd10);
        exp_all(64'h0, 64'h0, 1'b0, 1'b0, "alloc_pre");
        cyc();
        idle();
        exp_all(64'h0, 64'h0, 1'b1, 1'b1, "alloc_busy");
        cyc();
        wr(0, 5'd10, 64'h10);
        exp_all(64'h10, 64'h0, 1'b0, 1'b1, "wr_clear_busy");
        cyc();
        idle();
        exp_all(64'h10, 64'h10, 1'b0, 1'b0, "busy_cleared");
        cyc();
        wr(0, 5'd10, 64'h20);
        alloc_en   = 1'b1;
        alloc_addr = 5'd10;
        exp_all(64'h20, 64'h10, 1'b0, 1'b0, "alloc_wr_same");
        cyc();
        idle();
        exp_all(64'h20, 64'h20, 1'b1, 1'b1, "alloc_wins");
        cyc();

        // Stall blocks write to f4 and allocation of f6
        stall = 1'b1;
        wr(0, 5'd4, 64'hABCD);
        alloc_en   = 1'b1;
        alloc_addr = 5'd6;
        rd_addr    = {5'd4, 5'd6, 5'd4};
        exp_rd(0, 64'h0, 64'h0, "stall_wr");
        exp_busy(1, 1'b0, 1'b0, "stall_alloc");
        cyc();
        exp_rd(0, 64'h0, 64'h0, "stall_hold_wr");
        exp_rd(2, 64'h0, 64'h0, "stall_hold_wr");
        exp_busy(1, 1'b0, 1'b0, "stall_hold_alloc");
        cyc();
        stall = 1'b0;
        exp_rd(0, 64'hABCD, 64'h0, "nostall_wr_same");
        exp_busy(1, 1'b0, 1'b0, "nostall_alloc_same");
        cyc();
        idle();
        exp_rd(0, 64'hABCD, 64'hABCD, "nostall_wr");
        exp_rd(1, 64'h0, 64'h0, "nostall_f6_data");
        exp_busy(1, 1'b1, 1'b1, "nostall_alloc");
        cyc();

        // Mid-operation reset with f2 busy and holding data
        wr(0, 5'd2, 64'h55);
        alloc_en   = 1'b1;
        alloc_addr = 5'd2;
        rd_all(5'd2);
        cyc();
        idle();
        exp_all(64'h55, 64'h55, 1'b1, 1'b1, "pre_reset");
        exp_ready(1'b1, "pre_reset_ready");
        cyc();
        rst_n = 1'b0;
        exp_ready(1'b0, "rst_ready_drop");
        exp_all(64'h0, 64'h0, 1'b0, 1'b0, "rst_out");
        cyc();
        rst_n = 1'b1;
        clear_seq("reclear_ready");
        exp_all(64'h0, 64'h0, 1'b0, 1'b0, "f2_cleared");
        cyc();

        n_chk++;
        if (ready_b1 === 1'b1) begin
            n_pass++;
        end else begin
            $display("FAIL direct_ready bypass=1: got %b expected 1", ready_b1);
        end
        n_chk++;
        if (ready_b0 === 1'b1) begin
            n_pass++;
        end else begin
            $display("FAIL direct_ready bypass=0: got %b expected 1", ready_b0);
        end
        n_chk++;
        if (data_b1[DW-1:0] === 64'h0) begin
            n_pass++;
        end else begin
            $display("FAIL direct_f2 bypass=1: got %h expected 0", data_b1[DW-1:0]);
        end
        n_chk++;
        if (data_b0[DW-1:0] === 64'h0) begin
            n_pass++;
        end else begin
            $display("FAIL direct_f2 bypass=0: got %h expected 0", data_b0[DW-1:0]);
        end

        @(negedge clk);
        #1;
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_chk++;
            $display("FAIL %s: unchecked expectation %h left in scoreboard", e.name, e.val);
        end
        if (n_pass != n_chk) begin
            $display("TEST FAILED");
        end else begin
            $display("TEST PASSED");
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fp_regfile_mp.md
# fp_regfile_mp

Parametrised multi-port floating-point register file for the WB/ID boundary. It generalises the fixed 3-read/1-write FP regfile to N read and M write ports, with configurable write-to-read bypass. It adds a per-register busy scoreboard, so issue logic can detect pending producers from multi-cycle FPU pipelines. After reset it runs a hardware clear sequence, so every register starts at +0.0.

## Interface
- DEPTH, 32: number of FP registers; power of two, ≥2
- DATA_WIDTH, riscv_pkg::FpWidth: register width in bits
- NUM_READ, 3: read ports (fs1/fs2/fs3 plus extras); 1..6
- NUM_WRITE, 2: write ports (e.g. FPU pipe + load); 1..4
- BYPASS, 1: 1 = a same-cycle write is visible on the read ports; 0 = reads return the pre-write value
- AW: localparam, $clog2(DEPTH)

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_stall  in  1  pipeline stall; gates writes and allocations (not the clear sequence)
- i_rd_addr  in  NUM_READ×AW  read addresses (early source regs from PD)
- o_rd_data  out  NUM_READ×DATA_WIDTH  combinational read data
- o_rd_busy  out  NUM_READ  busy bit of the addressed register, combinational
- i_wr_en  in  NUM_WRITE  write enables
- i_wr_addr  in  NUM_WRITE×AW  write addresses (tracked FP dest reg)
- i_wr_data  in  NUM_WRITE×DATA_WIDTH  write data
- i_alloc_en  in  1  issue of an FP-writing instruction; marks its destination busy
- i_alloc_addr  in  AW  destination register being allocated
- o_ready  out  1  clear sequence complete; file usable

## Operation
- Storage is a DEPTH×DATA_WIDTH flop array. It has no async reset; contents are defined by the clear FSM. All registers, including f0, are writable.
- FSM states:
  - CLEAR: entered asynchronously while i_rst_n=0. Counter clr_idx resets to 0. Each cycle, writes 0 to entry clr_idx and increments. On the cycle clr_idx==DEPTH-1, it writes the final entry and moves to READY.
  - READY: normal operation. Only reset leaves it.
- During CLEAR:
  - i_wr_en and i_alloc_en are ignored.
  - o_rd_data is forced to 0 and o_rd_busy to 0.
  - i_stall has no effect.
- Effective write (READY only): i_wr_en[k] & ~i_stall.
- Effective allocation (READY only): i_alloc_en & ~i_stall.
- Write conflicts: when several ports write the same address in one cycle, the highest port index wins.
- Read path: o_rd_data[r] is the array entry at i_rd_addr[r].
- Bypass: if BYPASS=1 and any effective write targets i_rd_addr[r], o_rd_data[r] takes that write's data. The highest writing port wins, matching the storage result.
- Scoreboard: busy[DEPTH], async-reset to 0.
  - An effective write clears busy[addr] at the next edge.
  - An effective allocation sets busy[alloc_addr] at the next edge.
  - If an allocation and a write hit the same register in one cycle, the allocation wins: busy stays 1, because the new producer is younger.
- o_rd_busy[r] is busy[i_rd_addr[r]]. When BYPASS=1, a same-cycle effective write to that address forces it to 0, unless a same-cycle allocation targets the same address.
- Out-of-order completion: a write to a non-busy register is legal. It updates data and leaves busy at 0.

## Timing
- Reset values: o_ready=0, o_rd_data=0, o_rd_busy=0, busy[]=0, state=CLEAR, clr_idx=0.
- o_ready is registered; it goes to 1 at the DEPTH-th rising edge after i_rst_n deasserts (DEPTH cycles of clearing).
- Reset asserted mid-operation or mid-clear: outputs return to reset values immediately, and the clear restarts from index 0.
- Write latency: data is in storage after 1 edge. With BYPASS=1 it is visible on o_rd_data in the same cycle; with BYPASS=0 it is visible the cycle after the write.
- Scoreboard latency: a set or clear lands 1 edge after the allocation or write, apart from the same-cycle bypass override on o_rd_busy.
- Read paths are purely combinational from i_rd_addr, the array and the write ports; there is no read latency.

## Test plan
- Reset clear, DEPTH=32: release i_rst_n. o_ready stays 0 for 31 edges and is 1 after the 32nd. All 32 registers read 0x0. Writes attempted during CLEAR are dropped; reading f5 afterwards returns 0.
- Basic write/read: write f7=0x3FF0_0000_0000_0000 on port 0, then read f7 on all NUM_READ ports in the next cycle; every port returns that value.
- Bypass and conflict: ports 0 and 1 both write f3, with 0x1111 and 0x2222, while a read of f3 is active in the same cycle.
  - BYPASS=1: read shows 0x2222 the same cycle.
  - BYPASS=0: read shows the old value, then 0x2222 the next cycle.
- Scoreboard: allocate f10, and o_rd_busy goes to 1 next cycle. Write f10, and busy goes to 0 the same cycle when BYPASS=1. Allocating and writing f10 in the same cycle leaves busy=1.
- Stall: with i_stall=1, writing f4=0xABCD and allocating f6 leaves f4 and busy[6] unchanged. Deasserting i_stall and repeating both takes effect.
- Mid-operation reset: make f2 busy with data 0x55, then pulse i_rst_n low for 1 cycle. o_ready drops immediately and busy[2] is 0. After 32 cycles o_ready=1 and f2 reads 0.
